// File: rtl/rf_write_arbiter_if.sv
// Writeback bus between the ALU/load writeback stages, the arbiter and the register-file write port.
// The master side issues writeback requests; the slave side (the arbiter) grants and writes.
interface rf_write_arbiter_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
);
    logic              alu_valid;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;
    logic              mem_valid;
    logic [ADDR_W-1:0] mem_rd;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;
    logic              rf_wr_en;
    logic [ADDR_W-1:0] rf_wr_addr;
    logic [DATA_W-1:0] rf_wr_data;
    logic [CNT_W-1:0]  conflict_cnt;

    modport master (
        output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        input  alu_ready, mem_ready, rf_wr_en, rf_wr_addr, rf_wr_data, conflict_cnt
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        output alu_ready, mem_ready, rf_wr_en, rf_wr_addr, rf_wr_data, conflict_cnt
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU and load writeback,
// with XZR write suppression and a saturating contention counter.
module rf_write_arbiter #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 31,
    parameter int CNT_W    = 16
) (
    input  logic clk,
    input  logic reset,
    rf_write_arbiter_if.slave bus
);
    typedef enum logic {PRIO_ALU, PRIO_MEM} prio_t;

    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    prio_t             prio;
    logic              alu_grant;
    logic              mem_grant;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [CNT_W-1:0]  cnt;

    // Grants are masked during reset so nothing is accepted while the block is held.
    always_comb begin
        alu_grant = 1'b0;
        mem_grant = 1'b0;
        if (!reset) begin
            if (bus.alu_valid && (!bus.mem_valid || prio == PRIO_ALU))
                alu_grant = 1'b1;
            else if (bus.mem_valid)
                mem_grant = 1'b1;
        end
    end

    assign bus.alu_ready    = alu_grant;
    assign bus.mem_ready    = mem_grant;
    assign bus.rf_wr_en     = wr_en;
    assign bus.rf_wr_addr   = wr_addr;
    assign bus.rf_wr_data   = wr_data;
    assign bus.conflict_cnt = cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio    <= PRIO_ALU;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            cnt     <= '0;
        end else begin
            // Priority passes to whichever source did not just win.
            if (alu_grant)
                prio <= PRIO_MEM;
            else if (mem_grant)
                prio <= PRIO_ALU;

            wr_en <= 1'b0;
            if (alu_grant && bus.alu_rd != ZERO_IDX) begin
                wr_en   <= 1'b1;
                wr_addr <= bus.alu_rd;
                wr_data <= bus.alu_data;
            end else if (mem_grant && bus.mem_rd != ZERO_IDX) begin
                wr_en   <= 1'b1;
                wr_addr <= bus.mem_rd;
                wr_data <= bus.mem_data;
            end

            if (bus.alu_valid && bus.mem_valid && cnt != CNT_MAX)
                cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: table of single-cycle vectors plus reset and saturation sequences.
// A second instance with a 4-bit counter shares the same stimulus for the saturation check.
module tb_rf_write_arbiter;
    logic clk;
    logic reset;

    rf_write_arbiter_if #(.DATA_W(64), .ADDR_W(5), .CNT_W(16)) bus ();
    rf_write_arbiter_if #(.DATA_W(64), .ADDR_W(5), .CNT_W(4))  small_bus ();

    rf_write_arbiter #(.DATA_W(64), .ADDR_W(5), .ZERO_REG(31), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    rf_write_arbiter #(.DATA_W(64), .ADDR_W(5), .ZERO_REG(31), .CNT_W(4)) dut_small (
        .clk   (clk),
        .reset (reset),
        .bus   (small_bus)
    );

    assign small_bus.alu_valid = bus.alu_valid;
    assign small_bus.alu_rd    = bus.alu_rd;
    assign small_bus.alu_data  = bus.alu_data;
    assign small_bus.mem_valid = bus.mem_valid;
    assign small_bus.mem_rd    = bus.mem_rd;
    assign small_bus.mem_data  = bus.mem_data;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [63:0] ad;
        logic        mv;
        logic [4:0]  mrd;
        logic [63:0] md;
        logic        e_ar;
        logic        e_mr;
        logic        e_en;
        logic [4:0]  e_addr;
        logic [63:0] e_data;
        logic [15:0] e_cnt;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply_stimulus(input logic av, input logic [4:0] ard, input logic [63:0] ad,
                                  input logic mv, input logic [4:0] mrd, input logic [63:0] md);
        bus.alu_valid = av;
        bus.alu_rd    = ard;
        bus.alu_data  = ad;
        bus.mem_valid = mv;
        bus.mem_rd    = mrd;
        bus.mem_data  = md;
    endtask

    task automatic check_write(input string tag, input logic en, input logic [4:0] addr,
                               input logic [63:0] data, input logic [15:0] cnt);
        check({tag, " rf_wr_en"},     64'(bus.rf_wr_en),     64'(en));
        check({tag, " rf_wr_addr"},   64'(bus.rf_wr_addr),   64'(addr));
        check({tag, " rf_wr_data"},   bus.rf_wr_data,        data);
        check({tag, " conflict_cnt"}, 64'(bus.conflict_cnt), 64'(cnt));
    endtask

    initial begin
        // Pointer starts at ALU; each row notes the pointer after its edge.
        vecs[0]  = '{1'b1, 5'd3,  64'hAA,   1'b0, 5'd0,  64'h0,    1'b1, 1'b0, 1'b1, 5'd3, 64'hAA,   16'd0}; // ->MEM
        vecs[1]  = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,    1'b0, 1'b0, 1'b0, 5'd3, 64'hAA,   16'd0};
        vecs[2]  = '{1'b0, 5'd0,  64'h0,    1'b1, 5'd31, 64'hDEAD, 1'b0, 1'b1, 1'b0, 5'd3, 64'hAA,   16'd0}; // ->ALU
        vecs[3]  = '{1'b1, 5'd1,  64'h11,   1'b1, 5'd2,  64'h22,   1'b1, 1'b0, 1'b1, 5'd1, 64'h11,   16'd1};
        vecs[4]  = '{1'b1, 5'd4,  64'h44,   1'b1, 5'd2,  64'h22,   1'b0, 1'b1, 1'b1, 5'd2, 64'h22,   16'd2};
        vecs[5]  = '{1'b1, 5'd4,  64'h44,   1'b1, 5'd5,  64'h55,   1'b1, 1'b0, 1'b1, 5'd4, 64'h44,   16'd3};
        vecs[6]  = '{1'b1, 5'd6,  64'h66,   1'b1, 5'd5,  64'h55,   1'b0, 1'b1, 1'b1, 5'd5, 64'h55,   16'd4}; // ->ALU
        vecs[7]  = '{1'b1, 5'd7,  64'h5,    1'b1, 5'd7,  64'h9,    1'b1, 1'b0, 1'b1, 5'd7, 64'h5,    16'd5};
        vecs[8]  = '{1'b1, 5'd8,  64'h88,   1'b1, 5'd7,  64'h9,    1'b0, 1'b1, 1'b1, 5'd7, 64'h9,    16'd6}; // ->ALU
        vecs[9]  = '{1'b1, 5'd8,  64'h88,   1'b0, 5'd0,  64'h0,    1'b1, 1'b0, 1'b1, 5'd8, 64'h88,   16'd6}; // ->MEM
        vecs[10] = '{1'b1, 5'd31, 64'h1,    1'b1, 5'd9,  64'h99,   1'b0, 1'b1, 1'b1, 5'd9, 64'h99,   16'd7}; // ->ALU
        vecs[11] = '{1'b1, 5'd31, 64'h1,    1'b0, 5'd0,  64'h0,    1'b1, 1'b0, 1'b0, 5'd9, 64'h99,   16'd7}; // ->MEM
        vecs[12] = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,    1'b0, 1'b0, 1'b0, 5'd9, 64'h99,   16'd7};

        reset = 1'b1;
        apply_stimulus(1'b1, 5'd1, 64'h1, 1'b1, 5'd2, 64'h2);
        #1;
        check("reset alu_ready", 64'(bus.alu_ready), 64'd0);
        check("reset mem_ready", 64'(bus.mem_ready), 64'd0);
        check_write("reset", 1'b0, 5'd0, 64'h0, 16'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        apply_stimulus(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            apply_stimulus(vecs[i].av, vecs[i].ard, vecs[i].ad, vecs[i].mv, vecs[i].mrd, vecs[i].md);
            #1;
            check($sformatf("vec%0d alu_ready", i), 64'(bus.alu_ready), 64'(vecs[i].e_ar));
            check($sformatf("vec%0d mem_ready", i), 64'(bus.mem_ready), 64'(vecs[i].e_mr));
            @(posedge clk);
            #1;
            check_write($sformatf("vec%0d", i), vecs[i].e_en, vecs[i].e_addr, vecs[i].e_data, vecs[i].e_cnt);
        end

        // Reset asserted mid-cycle while MEM holds priority and both sources request.
        @(negedge clk);
        apply_stimulus(1'b1, 5'd10, 64'hA0, 1'b1, 5'd11, 64'hB0);
        #1;
        check("prereset mem_ready", 64'(bus.mem_ready), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async alu_ready", 64'(bus.alu_ready), 64'd0);
        check("async mem_ready", 64'(bus.mem_ready), 64'd0);
        check_write("async", 1'b0, 5'd0, 64'h0, 16'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("release rf_wr_en", 64'(bus.rf_wr_en), 64'd0);
        check("release alu_ready", 64'(bus.alu_ready), 64'd1);
        check("release mem_ready", 64'(bus.mem_ready), 64'd0);
        @(posedge clk);
        #1;
        check_write("post-reset", 1'b1, 5'd10, 64'hA0, 16'd1);

        // Continuous contention for 20 cycles from a fresh reset.
        @(negedge clk);
        reset = 1'b1;
        apply_stimulus(1'b1, 5'd12, 64'hC0, 1'b1, 5'd13, 64'hD0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("sat%0d small cnt", i), 64'(small_bus.conflict_cnt), 64'((i > 15) ? 15 : i));
            check($sformatf("sat%0d cnt", i), 64'(bus.conflict_cnt), 64'(i));
            check($sformatf("sat%0d addr", i), 64'(bus.rf_wr_addr), (i % 2 == 1) ? 64'd12 : 64'd13);
        end
        @(negedge clk);
        apply_stimulus(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the single register-file write port between two writeback sources: the ALU result path and the load (memory) return path.
- Round-robin arbitration, one grant per cycle, registered write outputs built from flop stages.
- Suppresses writes to the zero register (XZR).
- Sits between the EX/MEM writeback stages and the register file write port. Reports a saturating contention count for performance debug.

Parameters:
DATA_W, 64, width of writeback data
ADDR_W, 5, width of register index
ZERO_REG, 31, register index whose writes are suppressed (XZR)
CNT_W, 16, width of contention counter

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
alu_valid  input  1  ALU writeback request
alu_rd  input  ADDR_W  ALU destination register
alu_data  input  DATA_W  ALU result
alu_ready  output  1  ALU request granted this cycle (combinational)
mem_valid  input  1  load writeback request
mem_rd  input  ADDR_W  load destination register
mem_data  input  DATA_W  load data
mem_ready  output  1  load request granted this cycle (combinational)
rf_wr_en  output  1  register-file write enable (registered)
rf_wr_addr  output  ADDR_W  register-file write address (registered)
rf_wr_data  output  DATA_W  register-file write data (registered)
conflict_cnt  output  CNT_W  cycles in which both sources were valid (saturating)

Behaviour:
- Reset is asynchronous and active-high: it takes effect immediately on assertion, independent of clk.
  - While reset is asserted: rf_wr_en=0, rf_wr_addr=0, rf_wr_data=0, conflict_cnt=0.
  - While reset is asserted: priority pointer = ALU, and alu_ready=mem_ready=0.
- Handshake:
  - A transfer occurs on a cycle where valid && ready for a source.
  - A requester holds valid, rd and data stable until its transfer.
  - valid must not depend combinationally on ready.
  - ready is asserted only when the matching valid is high.
- Grant (combinational, per cycle):
  - Neither valid: no grant.
  - Exactly one valid: grant that source.
  - Both valid: grant the source named by the priority pointer.
- Priority pointer: on any transfer, it switches to the other source. With no transfer, it holds.
  - Result: under continuous contention the grants alternate ALU, MEM, ALU, MEM...
  - First contention after reset goes to ALU.
- Write output, fixed latency of 1 cycle from the transfer edge:
  - On the edge closing a transfer with rd != ZERO_REG: rf_wr_en<=1, rf_wr_addr<=rd, rf_wr_data<=data.
  - Transfer with rd == ZERO_REG: the transfer completes (ready still asserted), but rf_wr_en<=0 and addr/data hold their previous values.
  - No transfer: rf_wr_en<=0 and addr/data hold.
- Same rd from both sources in one cycle: the writes are serialized in grant order, so the later-granted value is the final register-file content.
- conflict_cnt: increments by 1 on each edge where alu_valid && mem_valid. It saturates at 2^CNT_W-1 and does not wrap.
- Reset mid-operation: a transfer granted in the cycle reset asserts is discarded; no write appears after reset deasserts.
- First cycle after reset deassertion: normal arbitration, ALU priority.

Test Plan:
- Reset: assert reset asynchronously mid-cycle with both valid -> outputs immediately 0, both ready=0; after release, the first contention grants ALU.
- Single source: alu_valid=1, rd=3, data=0xAA for 1 cycle -> alu_ready=1 same cycle; next cycle rf_wr_en=1, addr=3, data=0xAA; the following cycle rf_wr_en=0.
- Contention: both valid continuously for 4 cycles (ALU rd=1 data=0x11, MEM rd=2 data=0x22, holding until accepted, then new values) -> grant sequence ALU, MEM, ALU, MEM; rf_wr_addr sequence 1, 2, ... one cycle later; conflict_cnt=4.
- Zero register: mem_valid=1, mem_rd=31 -> mem_ready=1; next cycle rf_wr_en=0 and rf_wr_addr/data unchanged from the prior write.
- Same destination: both valid with rd=7, ALU data=0x5, MEM data=0x9, pointer at ALU -> writes 0x5 then 0x9 on consecutive cycles; register 7 ends at 0x9.
- Saturation: CNT_W=4, both valid for 20 cycles -> conflict_cnt reaches 15 and holds.
